maze_move_engine: RTL

Parametrised game-session engine for the maze game. It owns the player position, move counting, tile legality, score adjustments, the game timer and the win/lose decision. It sits between the PS2 keyboard receiver, the maze memory read port and the VGA draw/erase sequencers. Unlike the previous fixed 5-bit/32x32 integration, it takes grid size, limits, start point and bonus magnitude as parameters. It adds break-code filtering and a one-entry key buffer.

---
 rtl/maze_move_engine_if.sv | 31 +++
 rtl/maze_move_engine.sv | 137 +++++++++++++
 2 files changed

// File: rtl/maze_move_engine_if.sv
// maze_move_engine_if: keyboard, maze-memory, sequencer and status signals of the maze game engine
// master: the engine (drives requests, position, score and status)
// slave : the surroundings (keyboard, memory read port, draw/erase sequencers, soft restart)
interface maze_move_engine_if #(
  parameter int COORD_W = 5,
  parameter int MOVES_W = 8,
  parameter int TIME_W  = 7
);
  logic               restart;
  logic               key_valid;
  logic [7:0]         key_code;
  logic               mem_rd_req;
  logic [COORD_W-1:0] mem_x, mem_y;
  logic               mem_rd_valid;
  logic [2:0]         mem_rd_data;
  logic               erase_req, draw_req, draw_done;
  logic [COORD_W-1:0] pos_x, pos_y, prev_x, prev_y;
  logic [MOVES_W-1:0] moves;
  logic [TIME_W-1:0]  time_elapsed;
  logic               busy, game_won, game_over;
  modport master (
    input  restart, key_valid, key_code, mem_rd_valid, mem_rd_data, draw_done,
    output mem_rd_req, mem_x, mem_y, erase_req, draw_req, pos_x, pos_y, prev_x, prev_y,
           moves, time_elapsed, busy, game_won, game_over
  );
  modport slave (
    output restart, key_valid, key_code, mem_rd_valid, mem_rd_data, draw_done,
    input  mem_rd_req, mem_x, mem_y, erase_req, draw_req, pos_x, pos_y, prev_x, prev_y,
           moves, time_elapsed, busy, game_won, game_over
  );
endinterface

// File: rtl/maze_move_engine.sv
// maze_move_engine: maze game session engine (key filter, move legality, scoring, timer, win/lose)
// clock, resetn : system clock, asynchronous active-low reset
// io_bus        : master side of maze_move_engine_if (keys/restart in, tile read, erase/draw handshake, status out)
module maze_move_engine #(
  parameter int COORD_W       = 5,
  parameter int GRID_MAX      = 31,
  parameter int START_X       = 1,
  parameter int START_Y       = 0,
  parameter int MOVES_W       = 8,
  parameter int MAX_MOVES     = 200,
  parameter int TIME_W        = 7,
  parameter int MAX_TIME      = 99,
  parameter int TICKS_PER_SEC = 50000000,
  parameter int BONUS         = 5
) (
  input logic             clock,
  input logic             resetn,
  maze_move_engine_if.master io_bus
);
  typedef enum logic [2:0] {IDLE, CHECK, WAIT_MEM, ERASE, DRAW, WON, OVER} state_t;
  localparam int TICK_W = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [COORD_W-1:0] SX = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] SY = COORD_W'(START_Y);
  state_t             r_state;
  logic               r_brk, r_buf_v, r_rd_req;
  logic [1:0]         r_buf_dir, r_dir;
  logic [2:0]         r_tile;
  logic [COORD_W-1:0] r_pos_x, r_pos_y, r_prev_x, r_prev_y, r_tx, r_ty;
  logic [MOVES_W-1:0] r_moves;
  logic [TIME_W-1:0]  r_time;
  logic [TICK_W-1:0]  r_tick;
  logic               w_key, w_oob, w_texp, w_wrap, w_live;
  logic [1:0]         w_kd;
  logic [COORD_W:0]   w_tx, w_ty;
  int                 w_m1, w_mn;
  // direction: 0 up (W), 1 left (A), 2 down (S), 3 right (D)
  assign w_kd = io_bus.key_code == 8'h1D ? 2'd0 : io_bus.key_code == 8'h1C ? 2'd1 :
                io_bus.key_code == 8'h1B ? 2'd2 : 2'd3;
  assign w_key = io_bus.key_valid && !r_brk && (io_bus.key_code inside {8'h1D, 8'h1C, 8'h1B, 8'h23});
  // one extra bit so a step below zero wraps to a value above GRID_MAX
  assign w_tx = r_dir == 2'd3 ? {1'b0, r_pos_x} + (COORD_W+1)'(1) :
                r_dir == 2'd1 ? {1'b0, r_pos_x} - (COORD_W+1)'(1) : {1'b0, r_pos_x};
  assign w_ty = r_dir == 2'd2 ? {1'b0, r_pos_y} + (COORD_W+1)'(1) :
                r_dir == 2'd0 ? {1'b0, r_pos_y} - (COORD_W+1)'(1) : {1'b0, r_pos_y};
  assign w_oob  = int'(w_tx) > GRID_MAX || int'(w_ty) > GRID_MAX;
  assign w_texp = int'(r_time) >= MAX_TIME;
  assign w_wrap = int'(r_tick) == TICKS_PER_SEC - 1;
  assign w_live = r_state != WON && r_state != OVER;
  always_comb begin
    w_m1 = int'(r_moves) + 1;
    w_mn = r_tile == 3'd4 ? (w_m1 + BONUS > MAX_MOVES ? MAX_MOVES : w_m1 + BONUS) :
           r_tile == 3'd3 ? (w_m1 > BONUS ? w_m1 - BONUS : 0) : w_m1;
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      r_tick <= '0;
      r_time <= '0;
    end else if (io_bus.restart) begin
      r_tick <= '0;
      r_time <= '0;
    end else begin
      r_tick <= w_wrap ? '0 : r_tick + 1'b1;
      if (w_wrap && !w_texp && w_live) r_time <= r_time + 1'b1;
    end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      r_state <= IDLE; r_brk <= 1'b0; r_buf_v <= 1'b0; r_buf_dir <= '0; r_dir <= '0;
      r_tile <= '0; r_rd_req <= 1'b0; r_moves <= '0; r_tx <= SX; r_ty <= SY;
      r_pos_x <= SX; r_pos_y <= SY; r_prev_x <= SX; r_prev_y <= SY;
    end else if (io_bus.restart) begin
      r_state <= IDLE; r_brk <= 1'b0; r_buf_v <= 1'b0; r_buf_dir <= '0; r_dir <= '0;
      r_tile <= '0; r_rd_req <= 1'b0; r_moves <= '0; r_tx <= SX; r_ty <= SY;
      r_pos_x <= SX; r_pos_y <= SY; r_prev_x <= SX; r_prev_y <= SY;
    end else begin
      r_rd_req <= 1'b0;
      // the byte after a break prefix is swallowed and clears the flag
      if (io_bus.key_valid) r_brk <= !r_brk && io_bus.key_code == 8'hF0;
      // keys arriving while a move is in flight land in the buffer; IDLE/terminal states refine this below
      if (w_key) begin
        r_buf_v   <= 1'b1;
        r_buf_dir <= w_kd;
      end
      case (r_state)
        IDLE:
          if (w_texp) r_state <= OVER;
          else if (r_buf_v) begin
            r_dir   <= r_buf_dir;
            r_buf_v <= w_key;
            r_state <= CHECK;
          end else if (w_key) begin
            r_dir   <= w_kd;
            r_buf_v <= 1'b0;
            r_state <= CHECK;
          end
        CHECK:
          if (w_oob) r_state <= IDLE;
          else begin
            r_tx     <= w_tx[COORD_W-1:0];
            r_ty     <= w_ty[COORD_W-1:0];
            r_rd_req <= 1'b1;
            r_state  <= WAIT_MEM;
          end
        WAIT_MEM:
          if (io_bus.mem_rd_valid) begin
            r_tile  <= io_bus.mem_rd_data;
            r_state <= io_bus.mem_rd_data == 3'd1 ? IDLE : ERASE;
          end
        ERASE:
          if (io_bus.draw_done) begin
            r_prev_x <= r_pos_x;
            r_prev_y <= r_pos_y;
            r_pos_x  <= r_tx;
            r_pos_y  <= r_ty;
            r_moves  <= MOVES_W'(w_mn);
            r_state  <= DRAW;
          end
        DRAW:
          if (io_bus.draw_done)
            r_state <= r_tile == 3'd2 ? WON : (int'(r_moves) >= MAX_MOVES || w_texp) ? OVER : IDLE;
        default: r_buf_v <= 1'b0;
      endcase
    end
  assign io_bus.mem_rd_req   = r_rd_req;
  assign io_bus.mem_x        = r_tx;
  assign io_bus.mem_y        = r_ty;
  assign io_bus.erase_req    = r_state == ERASE;
  assign io_bus.draw_req     = r_state == DRAW;
  assign io_bus.pos_x        = r_pos_x;
  assign io_bus.pos_y        = r_pos_y;
  assign io_bus.prev_x       = r_prev_x;
  assign io_bus.prev_y       = r_prev_y;
  assign io_bus.moves        = r_moves;
  assign io_bus.time_elapsed = r_time;
  assign io_bus.busy         = r_state inside {CHECK, WAIT_MEM, ERASE, DRAW};
  assign io_bus.game_won     = r_state == WON;
  assign io_bus.game_over    = r_state == OVER;
endmodule
